video_pattern_src_core: RTL and testbench

//  Stream source for the video core chain: generates test-pattern pixels with frame coordinates
//  on the snk vld/rdy/vga_fc_t/rgb interface consumed by processing cores (e.g. rgb2gray).

---
 rtl/video_pattern_src_core_pkg.sv | 24 ++
 rtl/video_pattern_gen.sv | 56 +++++
 rtl/video_pattern_src_core.sv | 182 ++++++++++++++++++
 tb/tb_video_pattern_src_core.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pattern_src_core_pkg.sv
// Shared types for the video pattern source: pattern modes, register map, frame coordinates.
package video_pattern_src_core_pkg;

    typedef enum logic [1:0] {
        PM_SOLID   = 2'd0,
        PM_BARS    = 2'd1,
        PM_CHECKER = 2'd2,
        PM_GRAD    = 2'd3
    } pattern_mode_t;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_COLOR = 2'd1;
    localparam logic [1:0] REG_CHK   = 2'd2;
    localparam logic [1:0] REG_FCNT  = 2'd3;

    // Coordinate width covers up to 2047 pixels/lines.
    localparam int FC_W = 11;

    typedef struct packed {
        logic [FC_W-1:0] hc;
        logic [FC_W-1:0] vc;
    } vga_fc_t;

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational pattern colour for one pixel from its coordinates and the frame's settings.
module video_pattern_gen
    import video_pattern_src_core_pkg::*;
#(
    parameter int RSIZE     = 4,
    parameter int GSIZE     = 4,
    parameter int BSIZE     = 4,
    parameter int RGB_SIZE  = RSIZE + GSIZE + BSIZE,
    parameter int H_DISPLAY = 640,
    parameter int X_W       = 10,
    parameter int Y_W       = 9
) (
    input  logic [X_W-1:0]      i_x,
    input  logic [Y_W-1:0]      i_y,
    input  pattern_mode_t       i_mode,
    input  logic [RGB_SIZE-1:0] i_color,
    input  logic [3:0]          i_chk_shift,
    input  logic [GSIZE-1:0]    i_lvl,
    output logic [RGB_SIZE-1:0] o_rgb
);

    localparam int BAR_W = H_DISPLAY / 8;
    localparam int C_W   = (X_W > Y_W) ? X_W : Y_W;

    logic [2:0]       w_bar;
    logic             w_chk;
    logic [RSIZE-1:0] w_gr;
    logic [BSIZE-1:0] w_gb;

    // Bar index from constant thresholds; no divider on x.
    always_comb begin
        w_bar = '0;
        for (int k = 1; k < 8; k++) begin
            if (int'(i_x) >= k * BAR_W) w_bar = 3'(k);
        end
    end

    // (x>>s)^(y>>s) has the same lsb as (x^y)>>s.
    assign w_chk = |(((C_W'(i_x) ^ C_W'(i_y)) >> i_chk_shift) & C_W'(1));

    // Ramp level is green-width; red/blue take it msb-aligned.
    assign w_gr = RSIZE'({i_lvl, {RSIZE{1'b0}}} >> GSIZE);
    assign w_gb = BSIZE'({i_lvl, {BSIZE{1'b0}}} >> GSIZE);

    always_comb begin
        o_rgb = i_color;
        case (i_mode)
            PM_SOLID:   o_rgb = i_color;
            PM_BARS:    o_rgb = {{RSIZE{w_bar[2]}}, {GSIZE{w_bar[1]}}, {BSIZE{w_bar[0]}}};
            PM_CHECKER: o_rgb = {RGB_SIZE{w_chk}};
            PM_GRAD:    o_rgb = {w_gr, i_lvl, w_gb};
            default:    o_rgb = i_color;
        endcase
    end

endmodule

// File: rtl/video_pattern_src_core.sv
// Test-pattern stream source with Avalon-MM register file and vld/rdy pixel output.
// Optional frame counter at register 0x3 when VIDEO_PATTERN_FRAME_CNT_EN is defined.
module video_pattern_src_core
    import video_pattern_src_core_pkg::*;
#(
    parameter int RSIZE     = 4,
    parameter int GSIZE     = 4,
    parameter int BSIZE     = 4,
    parameter int RGB_SIZE  = RSIZE + GSIZE + BSIZE,
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_avs_write,
    input  logic                i_avs_read,
    input  logic [1:0]          i_avs_address,
    input  logic [31:0]         i_avs_writedata,
    output logic [31:0]         o_avs_readdata,
    input  logic                i_snk_rdy,
    output logic                o_snk_vld,
    output vga_fc_t             o_snk_fc,
    output logic [RGB_SIZE-1:0] o_snk_rgb
);

    localparam int X_W      = $clog2(H_DISPLAY);
    localparam int Y_W      = $clog2(V_DISPLAY);
    localparam int STEP_RAW = H_DISPLAY >> GSIZE;
    localparam int STEP     = (STEP_RAW < 1) ? 1 : STEP_RAW;
    localparam int S_W      = $clog2(STEP + 1);
    localparam logic [GSIZE-1:0] LVL_MAX = '1;

    logic                r_enable;
    pattern_mode_t       r_mode;
    logic [RGB_SIZE-1:0] r_color;
    logic [3:0]          r_chk_shift;
    pattern_mode_t       r_sh_mode;
    logic [RGB_SIZE-1:0] r_sh_color;
    logic [3:0]          r_sh_shift;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [S_W-1:0]      r_rcnt;
    logic [GSIZE-1:0]    r_lvl;

    logic                w_origin;
    logic                w_run;
    logic                w_load;
    logic                w_x_last;
    logic                w_y_last;
    pattern_mode_t       w_mode;
    logic [RGB_SIZE-1:0] w_color;
    logic [3:0]          w_shift;
    logic [RGB_SIZE-1:0] w_rgb;
    logic                w_unused_wdata;

    assign w_unused_wdata = ^i_avs_writedata[31:RGB_SIZE];

    assign w_origin = (r_x == '0) && (r_y == '0);
    // A started frame always runs to completion; enable only gates the frame start.
    assign w_run    = r_enable || !w_origin;
    assign w_load   = w_run && (!o_snk_vld || i_snk_rdy);
    assign w_x_last = (r_x == X_W'(H_DISPLAY - 1));
    assign w_y_last = (r_y == Y_W'(V_DISPLAY - 1));

    // The frame's first pixel sees the programmed values, which become the shadow on that load.
    assign w_mode  = w_origin ? r_mode      : r_sh_mode;
    assign w_color = w_origin ? r_color     : r_sh_color;
    assign w_shift = w_origin ? r_chk_shift : r_sh_shift;

    video_pattern_gen #(
        .RSIZE     (RSIZE),
        .GSIZE     (GSIZE),
        .BSIZE     (BSIZE),
        .RGB_SIZE  (RGB_SIZE),
        .H_DISPLAY (H_DISPLAY),
        .X_W       (X_W),
        .Y_W       (Y_W)
    ) u_gen (
        .i_x         (r_x),
        .i_y         (r_y),
        .i_mode      (w_mode),
        .i_color     (w_color),
        .i_chk_shift (w_shift),
        .i_lvl       (r_lvl),
        .o_rgb       (w_rgb)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_enable    <= 1'b0;
            r_mode      <= PM_SOLID;
            r_color     <= '0;
            r_chk_shift <= '0;
        end else if (i_avs_write) begin
            case (i_avs_address)
                REG_CTRL: begin
                    r_enable <= i_avs_writedata[0];
                    r_mode   <= pattern_mode_t'(i_avs_writedata[2:1]);
                end
                REG_COLOR: r_color     <= i_avs_writedata[RGB_SIZE-1:0];
                REG_CHK:   r_chk_shift <= i_avs_writedata[3:0];
                default: ;
            endcase
        end
    end

`ifdef VIDEO_PATTERN_FRAME_CNT_EN
    logic [31:0] r_fcnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fcnt <= '0;
        end else if (i_avs_write && (i_avs_address == REG_FCNT)) begin
            r_fcnt <= '0;
        end else if (o_snk_vld && i_snk_rdy &&
                     (o_snk_fc.hc == FC_W'(H_DISPLAY - 1)) &&
                     (o_snk_fc.vc == FC_W'(V_DISPLAY - 1))) begin
            r_fcnt <= r_fcnt + 32'd1;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_avs_readdata <= '0;
        end else if (i_avs_read) begin
            case (i_avs_address)
                REG_CTRL:  o_avs_readdata <= {29'd0, r_mode, r_enable};
                REG_COLOR: o_avs_readdata <= 32'(r_color);
                REG_CHK:   o_avs_readdata <= {28'd0, r_chk_shift};
`ifdef VIDEO_PATTERN_FRAME_CNT_EN
                default:   o_avs_readdata <= r_fcnt;
`else
                default:   o_avs_readdata <= '0;
`endif
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_snk_vld  <= 1'b0;
            o_snk_fc   <= '0;
            o_snk_rgb  <= '0;
            r_sh_mode  <= PM_SOLID;
            r_sh_color <= '0;
            r_sh_shift <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_rcnt     <= '0;
            r_lvl      <= '0;
        end else if (w_load) begin
            o_snk_vld   <= 1'b1;
            o_snk_fc.hc <= FC_W'(r_x);
            o_snk_fc.vc <= FC_W'(r_y);
            o_snk_rgb   <= w_rgb;
            if (w_origin) begin
                r_sh_mode  <= r_mode;
                r_sh_color <= r_color;
                r_sh_shift <= r_chk_shift;
            end
            if (w_x_last) begin
                r_x    <= '0;
                r_y    <= w_y_last ? '0 : r_y + 1'b1;
                r_rcnt <= '0;
                r_lvl  <= '0;
            end else begin
                r_x <= r_x + 1'b1;
                // Ramp level tracks x in steps of STEP pixels, clamped at full scale.
                if (r_rcnt == S_W'(STEP - 1)) begin
                    r_rcnt <= '0;
                    if (r_lvl != LVL_MAX) r_lvl <= r_lvl + 1'b1;
                end else begin
                    r_rcnt <= r_rcnt + 1'b1;
                end
            end
        end else if (i_snk_rdy) begin
            o_snk_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_pattern_src_core.sv
// Scoreboard bench for video_pattern_src_core; frame height is reduced to 10 lines to keep runs short.
module tb_video_pattern_src_core;
    import video_pattern_src_core_pkg::*;

    localparam int H  = 640;
    localparam int V  = 10;
    localparam int FR = H * V;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        avs_write = 1'b0;
    logic        avs_read = 1'b0;
    logic [1:0]  avs_address = 2'd0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        snk_rdy;
    logic        snk_vld;
    vga_fc_t     snk_fc;
    logic [11:0] snk_rgb;

    bit rnd_on = 1'b0;
    bit rnd_bit;

    int total = 0;
    int bad = 0;

    typedef struct {
        int          lin;
        logic [11:0] rgb;
    } exp_t;
    exp_t q[$];

    int          m_lin = 0;
    int          mx = 0;
    int          my = 0;
    bit          stall = 1'b0;
    vga_fc_t     st_fc;
    logic [11:0] st_rgb;

    video_pattern_src_core #(
        .RSIZE     (4),
        .GSIZE     (4),
        .BSIZE     (4),
        .RGB_SIZE  (12),
        .H_DISPLAY (H),
        .V_DISPLAY (V)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_avs_write     (avs_write),
        .i_avs_read      (avs_read),
        .i_avs_address   (avs_address),
        .i_avs_writedata (avs_writedata),
        .o_avs_readdata  (avs_readdata),
        .i_snk_rdy       (snk_rdy),
        .o_snk_vld       (snk_vld),
        .o_snk_fc        (snk_fc),
        .o_snk_rgb       (snk_rgb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end
    assign snk_rdy = rnd_on ? rnd_bit : 1'b1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    function automatic void push(input int lin, input logic [11:0] rgb);
        exp_t e;
        e.lin = lin;
        e.rgb = rgb;
        q.push_back(e);
    endfunction

    // Monitor: coordinate sequence, stall stability, and scoreboard colour checks.
    always @(negedge clk) begin
        if (rst) begin
            m_lin = 0;
            mx = 0;
            my = 0;
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_vld", 32'(snk_vld), 32'd1);
                chk("stall_fc", 32'(snk_fc), 32'(st_fc));
                chk("stall_rgb", 32'(snk_rgb), 32'(st_rgb));
            end
            stall = 1'b0;
            if (snk_vld && !snk_rdy) begin
                stall = 1'b1;
                st_fc = snk_fc;
                st_rgb = snk_rgb;
            end
            if (snk_vld && snk_rdy) begin
                chk("beat_hc", 32'(snk_fc.hc), 32'(mx));
                chk("beat_vc", 32'(snk_fc.vc), 32'(my));
                while (q.size() > 0 && q[0].lin < m_lin) begin
                    chk("vec_missed", 32'(q[0].lin), 32'(m_lin));
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].lin == m_lin) begin
                    chk($sformatf("pix_rgb f%0d x%0d y%0d", m_lin / FR, mx, my), 32'(snk_rgb), 32'(q[0].rgb));
                    void'(q.pop_front());
                end
                m_lin++;
                if (mx == H - 1) begin
                    mx = 0;
                    my = (my == V - 1) ? 0 : my + 1;
                end else begin
                    mx++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_write = 1'b1;
        avs_address = a;
        avs_writedata = d;
        tick;
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs_read = 1'b1;
        avs_address = a;
        tick;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wait_lin(input int tgt, input string nm);
        int n = 0;
        while (m_lin < tgt && n < 40000) begin
            tick;
            n++;
        end
        chk(nm, 32'(m_lin >= tgt), 32'd1);
    endtask

    initial begin
        logic [11:0] bars [8];
        logic [31:0] d;
        logic [11:0] c;
        int          lvl;
        int          exp_fcnt;

        bars = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};

        repeat (3) tick;
        chk("rst_vld", 32'(snk_vld), 32'd0);
        chk("rst_fc", 32'(snk_fc), 32'd0);
        chk("rst_rgb", 32'(snk_rgb), 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            chk($sformatf("rst_reg%0d", a), d, 32'd0);
        end

        // Frames: 0 SOLID F00, 1 BARS, 2 CHECKER s=3, 3 SOLID 0A5, 4 GRAD.
        for (int f = 0; f < 5; f++) begin
            for (int y = 0; y < V; y++) begin
                for (int x = 0; x < H; x++) begin
                    case (f)
                        0: c = 12'hF00;
                        1: c = bars[x / 80];
                        2: c = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 12'hFFF : 12'h000;
                        3: c = 12'h0A5;
                        default: begin
                            lvl = (x / 40 > 15) ? 15 : x / 40;
                            c = 12'(12'h111 * lvl);
                        end
                    endcase
                    push(f * FR + y * H + x, c);
                end
            end
        end

        wr(REG_COLOR, 32'h0000_0F00);
        avs_write = 1'b1;
        avs_address = REG_CTRL;
        avs_writedata = 32'd1;
        tick;
        avs_write = 1'b0;
        chk("lat_n1_vld", 32'(snk_vld), 32'd0);
        tick;
        chk("lat_n2_vld", 32'(snk_vld), 32'd1);

        wr(REG_CTRL, 32'd3);
        rd(REG_CTRL, d);
        chk("rd_ctrl_bars", d, 32'd3);

        wait_lin(FR + 1, "wait_f1");
        wr(REG_CHK, 32'd3);
        wr(REG_CTRL, 32'd5);

        wait_lin(2 * FR + 1, "wait_f2");
        rnd_on = 1'b1;
        wr(REG_COLOR, 32'h0000_00A5);
        wr(REG_CTRL, 32'd1);

        wait_lin(3 * FR + 1, "wait_f3");
        rnd_on = 1'b0;
        wait_lin(3 * FR + 5 * H + 101, "wait_f3_mid");
        wr(REG_CTRL, 32'd7);
        rd(REG_CTRL, d);
        chk("rd_ctrl_grad", d, 32'd7);

        wait_lin(4 * FR + 3 * H, "wait_f4_mid");
        wr(REG_CTRL, 32'd6);
        wait_lin(5 * FR, "drain");
        chk("drain_vld0", 32'(snk_vld), 32'd0);
        repeat (3) tick;
        chk("drain_idle", 32'(snk_vld), 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        rd(REG_CTRL, d);
        chk("rd_ctrl", d, 32'd6);
        rd(REG_COLOR, d);
        chk("rd_color", d, 32'h0A5);
        rd(REG_CHK, d);
        chk("rd_chk", d, 32'd3);
`ifdef VIDEO_PATTERN_FRAME_CNT_EN
        exp_fcnt = 5;
`else
        exp_fcnt = 0;
`endif
        rd(REG_FCNT, d);
        chk("rd_fcnt", d, 32'(exp_fcnt));
        wr(REG_FCNT, 32'd0);
        rd(REG_FCNT, d);
        chk("rd_fcnt_clr", d, 32'd0);

        wr(REG_CTRL, 32'd1);
        wait_lin(5 * FR + 50, "wait_rerun");
        rd(REG_COLOR, d);
        rst = 1'b1;
        tick;
        chk("midrst_vld", 32'(snk_vld), 32'd0);
        chk("midrst_fc", 32'(snk_fc), 32'd0);
        chk("midrst_rgb", 32'(snk_rgb), 32'd0);
        chk("midrst_rdata", avs_readdata, 32'd0);
        tick;
        rst = 1'b0;
        rd(REG_CTRL, d);
        chk("midrst_ctrl", d, 32'd0);
        rd(REG_COLOR, d);
        chk("midrst_color", d, 32'd0);

        for (int i = 0; i < 16; i++) push(i, 12'h3C3);
        wr(REG_COLOR, 32'h0000_03C3);
        wr(REG_CTRL, 32'd1);
        wait_lin(16, "wait_postrst");
        chk("postrst_queue", 32'(q.size()), 32'd0);
        wr(REG_CTRL, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
